// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: five independent channels, with master and slave views.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response stream into
// AXI reads and writes. Every AXI output and every response output is a flop.
module axi_lite_master #(
   parameter int         C_M_AXI_DATA_WIDTH = 32,
   parameter int         C_M_AXI_ADDR_WIDTH = 32,
   parameter logic [2:0] C_AXPROT           = 3'b000
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   axi_lite_if.master                      m_axi
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]                      state_r;
   logic                            cmd_ready_r;
   logic                            awvalid_r;
   logic                            wvalid_r;
   logic                            bready_r;
   logic                            arvalid_r;
   logic                            rready_r;
   logic                            rsp_valid_r;
   logic                            rsp_write_r;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_r;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_r;
   logic [1:0]                      rsp_resp_r;

   // A channel counts as done once its valid has dropped or it handshakes now,
   // so AW and W may complete in either order or together.
   logic aw_done_s;
   logic w_done_s;
   logic cmd_fire_s;
   logic b_fire_s;
   logic r_fire_s;
   logic rsp_fire_s;

   assign aw_done_s  = ~awvalid_r | m_axi.awready;
   assign w_done_s   = ~wvalid_r | m_axi.wready;
   assign cmd_fire_s = cmd_valid & cmd_ready_r;
   assign b_fire_s   = m_axi.bvalid & bready_r;
   assign r_fire_s   = m_axi.rvalid & rready_r;
   assign rsp_fire_s = rsp_valid_r & rsp_ready;

   assign cmd_ready      = cmd_ready_r;
   assign rsp_valid      = rsp_valid_r;
   assign rsp_write      = rsp_write_r;
   assign rsp_rdata      = rsp_rdata_r;
   assign rsp_resp       = rsp_resp_r;
   assign m_axi.awaddr   = awaddr_r;
   assign m_axi.awprot   = C_AXPROT;
   assign m_axi.awvalid  = awvalid_r;
   assign m_axi.wdata    = wdata_r;
   assign m_axi.wstrb    = wstrb_r;
   assign m_axi.wvalid   = wvalid_r;
   assign m_axi.bready   = bready_r;
   assign m_axi.araddr   = araddr_r;
   assign m_axi.arprot   = C_AXPROT;
   assign m_axi.arvalid  = arvalid_r;
   assign m_axi.rready   = rready_r;

   // Transaction sequencer: one command in flight from acceptance to response handshake.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r     <= S_IDLE;
         cmd_ready_r <= 1'b1;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_write_r <= 1'b0;
         awaddr_r    <= '0;
         araddr_r    <= '0;
         wdata_r     <= '0;
         wstrb_r     <= '0;
         rsp_rdata_r <= '0;
         rsp_resp_r  <= 2'b00;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (cmd_fire_s) begin
                  cmd_ready_r <= 1'b0;
                  if (cmd_write) begin
                     awaddr_r  <= cmd_addr;
                     wdata_r   <= cmd_wdata;
                     wstrb_r   <= cmd_wstrb;
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= S_WRITE;
                  end else begin
                     araddr_r  <= cmd_addr;
                     arvalid_r <= 1'b1;
                     state_r   <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               if (awvalid_r && m_axi.awready) begin
                  awvalid_r <= 1'b0;
               end
               if (wvalid_r && m_axi.wready) begin
                  wvalid_r <= 1'b0;
               end
               if (aw_done_s && w_done_s) begin
                  bready_r <= 1'b1;
                  state_r  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (b_fire_s) begin
                  bready_r    <= 1'b0;
                  rsp_resp_r  <= m_axi.bresp;
                  rsp_write_r <= 1'b1;
                  rsp_rdata_r <= '0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= S_RESP;
               end
            end
            S_READ: begin
               if (m_axi.arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (r_fire_s) begin
                  rready_r    <= 1'b0;
                  rsp_rdata_r <= m_axi.rdata;
                  rsp_resp_r  <= m_axi.rresp;
                  rsp_write_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_fire_s) begin
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  state_r     <= S_IDLE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               cmd_ready_r <= 1'b1;
               awvalid_r   <= 1'b0;
               wvalid_r    <= 1'b0;
               bready_r    <= 1'b0;
               arvalid_r   <= 1'b0;
               rready_r    <= 1'b0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a 4-register AXI4-Lite slave model
// whose per-channel ready/valid latencies and response codes are adjustable.
module tb_axi_lite_master;

   logic        aclk      = 1'b0;
   logic        aresetn   = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = 32'h0;
   logic [31:0] cmd_wdata = 32'h0;
   logic [3:0]  cmd_wstrb = 4'h0;
   logic        rsp_ready = 1'b0;
   logic        cmd_ready;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_master #(
      .C_M_AXI_DATA_WIDTH(32),
      .C_M_AXI_ADDR_WIDTH(32),
      .C_AXPROT(3'b000)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi(bus)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // slave knobs
   int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
   logic [1:0]  resp_sel   = 2'b00;
   logic        force_en   = 1'b0;
   logic [31:0] force_data = 32'h0;

   // slave state
   logic [31:0] mem [0:3];
   int          aw_cnt, w_cnt, ar_cnt, r_cnt;
   logic        aw_got, w_got, r_pend;
   logic [31:0] aw_addr_q, ar_addr_q, w_data_q;
   logic [3:0]  w_strb_q;

   // handshake monitors
   int aw_hs = 0, w_hs = 0, rsp_beats = 0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   // 4-register slave with programmable latencies
   always @(posedge aclk) begin
      if (!aresetn) begin
         bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
         bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= 32'h0; bus.rresp <= 2'b00;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
         aw_addr_q <= 32'h0; ar_addr_q <= 32'h0; w_data_q <= 32'h0; w_strb_q <= 4'h0;
         for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
      end else begin
         if (bus.awvalid && bus.awready) begin
            bus.awready <= 1'b0; aw_got <= 1'b1; aw_addr_q <= bus.awaddr; aw_cnt <= 0;
         end else if (bus.awvalid && !aw_got) begin
            if (aw_cnt >= aw_lat) bus.awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
         end
         if (bus.wvalid && bus.wready) begin
            bus.wready <= 1'b0; w_got <= 1'b1; w_data_q <= bus.wdata; w_strb_q <= bus.wstrb; w_cnt <= 0;
         end else if (bus.wvalid && !w_got) begin
            if (w_cnt >= w_lat) bus.wready <= 1'b1; else w_cnt <= w_cnt + 1;
         end
         if (bus.bvalid && bus.bready) begin
            bus.bvalid <= 1'b0;
         end else if (aw_got && w_got && !bus.bvalid) begin
            mem[aw_addr_q[3:2]] <= merge(mem[aw_addr_q[3:2]], w_data_q, w_strb_q);
            bus.bvalid <= 1'b1; bus.bresp <= resp_sel; aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0; r_pend <= 1'b1; r_cnt <= 0; ar_addr_q <= bus.araddr; ar_cnt <= 0;
         end else if (bus.arvalid && !r_pend) begin
            if (ar_cnt >= ar_lat) bus.arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
         end
         if (bus.rvalid && bus.rready) begin
            bus.rvalid <= 1'b0;
         end else if (r_pend && !bus.rvalid) begin
            if (r_cnt >= r_lat) begin
               bus.rvalid <= 1'b1; bus.rresp <= resp_sel; r_pend <= 1'b0;
               bus.rdata  <= force_en ? force_data : mem[ar_addr_q[3:2]];
            end else begin
               r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // handshake counters
   always @(posedge aclk) begin
      if (bus.awvalid && bus.awready) aw_hs <= aw_hs + 1;
      if (bus.wvalid && bus.wready) w_hs <= w_hs + 1;
      if (rsp_valid && rsp_ready) rsp_beats <= rsp_beats + 1;
   end

   // drive one command and wait (bounded) for its acceptance; returns on the negedge after it
   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout addr=%h", a);
      end
      @(negedge aclk);
      cmd_valid = 1'b0;
   endtask

   // accept one response (bounded wait); returns on the negedge after the handshake
   task automatic get_rsp(output logic w, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
      if (!rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_timeout");
      end
      w = rsp_write; d = rsp_rdata; r = rsp_resp;
      @(negedge aclk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid} !== 6'b0) begin
         errors++; $display("FAIL reset_valids got %b exp 000000",
            {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid});
      end
      checks++;
      if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, rsp_rdata, rsp_resp, rsp_write} !== 135'h0) begin
         errors++; $display("FAIL reset_payload got nonzero awaddr=%h wdata=%h rdata=%h", bus.awaddr, bus.wdata, rsp_rdata);
      end
   endtask

   task automatic test_write_read();
      logic w; logic [31:0] d; logic [1:0] r;
      int aw0 = aw_hs, w0 = w_hs;
      send_cmd(1'b1, 32'h04, 32'hCAFEF00D, 4'hF);
      checks++;
      if ({bus.awvalid, bus.wvalid, cmd_ready} !== 3'b110) begin
         errors++; $display("FAIL wr_launch got aw/w/cmd_ready=%b exp 110", {bus.awvalid, bus.wvalid, cmd_ready});
      end
      checks++;
      if ({bus.awaddr, bus.wdata, bus.wstrb} !== {32'h04, 32'hCAFEF00D, 4'hF}) begin
         errors++; $display("FAIL wr_payload got %h %h %h exp 00000004 cafef00d f", bus.awaddr, bus.wdata, bus.wstrb);
      end
      get_rsp(w, d, r);
      checks++;
      if ({w, d, r} !== {1'b1, 32'h0, 2'b00}) begin
         errors++; $display("FAIL wr_rsp got write=%b rdata=%h resp=%b exp 1 00000000 00", w, d, r);
      end
      checks++;
      if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin
         errors++; $display("FAIL wr_hs_count got aw=%0d w=%0d exp 1 1", aw_hs - aw0, w_hs - w0);
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errors++; $display("FAIL rsp_single_cycle got rsp_valid/cmd_ready=%b exp 01", {rsp_valid, cmd_ready});
      end
      send_cmd(1'b0, 32'h04, 32'h0, 4'h0);
      get_rsp(w, d, r);
      checks++;
      if ({w, d, r} !== {1'b0, 32'hCAFEF00D, 2'b00}) begin
         errors++; $display("FAIL rd_back got write=%b rdata=%h resp=%b exp 0 cafef00d 00", w, d, r);
      end
   endtask

   task automatic test_multi();
      logic w; logic [31:0] d; logic [1:0] r;
      logic [31:0] vals [0:3];
      int b0 = rsp_beats;
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333; vals[3] = 32'h44444444;
      for (int i = 0; i < 4; i++) begin
         send_cmd(1'b1, 32'(i * 4), vals[i], 4'hF);
         get_rsp(w, d, r);
      end
      for (int i = 3; i >= 0; i--) begin
         send_cmd(1'b0, 32'(i * 4), 32'h0, 4'h0);
         get_rsp(w, d, r);
         checks++;
         if (d !== vals[i]) begin errors++; $display("FAIL multi_rd[%0d] got %h exp %h", i, d, vals[i]); end
      end
      checks++;
      if (rsp_beats - b0 !== 8) begin errors++; $display("FAIL multi_beats got %0d exp 8", rsp_beats - b0); end
   endtask

   task automatic test_aw_w_order(input int la, input int lw, input logic [31:0] data);
      logic w; logic [31:0] d; logic [1:0] r;
      int aw0 = aw_hs, w0 = w_hs;
      int aw_i = -1, w_i = -1;
      logic bad_aw = 1'b0, bad_w = 1'b0, bad_b = 1'b0, seen_b = 1'b0;
      aw_lat = la; w_lat = lw;
      send_cmd(1'b1, 32'h0C, data, 4'hF);
      for (int i = 0; i < 15; i++) begin
         if (bus.awvalid !== ((aw_hs == aw0) ? 1'b1 : 1'b0)) bad_aw = 1'b1;
         if (bus.wvalid !== ((w_hs == w0) ? 1'b1 : 1'b0)) bad_w = 1'b1;
         if (bus.bready === 1'b1) begin
            seen_b = 1'b1;
            if (aw_hs == aw0 || w_hs == w0) bad_b = 1'b1;
         end
         if (aw_i < 0 && aw_hs != aw0) aw_i = i;
         if (w_i < 0 && w_hs != w0) w_i = i;
         @(negedge aclk);
      end
      checks++;
      if ({bad_aw, bad_w} !== 2'b00) begin errors++; $display("FAIL order_valid_drop lat=%0d/%0d got bad aw/w=%b exp 00", la, lw, {bad_aw, bad_w}); end
      checks++;
      if ({seen_b, bad_b} !== 2'b10) begin errors++; $display("FAIL order_bready lat=%0d/%0d got seen/bad=%b exp 10", la, lw, {seen_b, bad_b}); end
      checks++;
      if (aw_i < 0 || w_i < 0 || (aw_i - w_i) != (la - lw)) begin
         errors++; $display("FAIL order_hs_gap got aw_i=%0d w_i=%0d exp gap %0d", aw_i, w_i, la - lw);
      end
      get_rsp(w, d, r);
      checks++;
      if ({w, r} !== {1'b1, 2'b00}) begin errors++; $display("FAIL order_rsp got write=%b resp=%b exp 1 00", w, r); end
      aw_lat = 0; w_lat = 0;
   endtask

   task automatic test_read_err();
      logic w; logic [31:0] d; logic [1:0] r;
      int n = 0, rr = 0;
      logic unstable = 1'b0;
      resp_sel = 2'b10; force_en = 1'b1; force_data = 32'h12345678; r_lat = 5;
      send_cmd(1'b0, 32'h0C, 32'h0, 4'h0);
      while (!rsp_valid && n < 100) begin
         if (bus.rready === 1'b1) rr++;
         @(negedge aclk); n++;
      end
      checks++;
      if (rr < 5) begin errors++; $display("FAIL rd_rready_wait got %0d cycles exp >=5", rr); end
      for (int i = 0; i < 4; i++) begin
         if ({rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp} !== {1'b1, 1'b0, 1'b0, 32'h12345678, 2'b10})
            unstable = 1'b1;
         @(negedge aclk);
      end
      checks++;
      if (unstable !== 1'b0) begin errors++; $display("FAIL rd_rsp_hold got unstable=%b exp 0", unstable); end
      get_rsp(w, d, r);
      checks++;
      if ({w, d, r} !== {1'b0, 32'h12345678, 2'b10}) begin
         errors++; $display("FAIL rd_slverr got write=%b rdata=%h resp=%b exp 0 12345678 10", w, d, r);
      end
      resp_sel = 2'b00; force_en = 1'b0; r_lat = 0;
   endtask

   task automatic test_back_to_back();
      logic w; logic [31:0] d; logic [1:0] r;
      int acc [0:1];
      int n_acc = 0, rsp_i = -1;
      logic [31:0] first_data = 32'h0;
      acc[0] = -1; acc[1] = -1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08; rsp_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (rsp_valid === 1'b1 && rsp_i < 0) begin rsp_i = i; first_data = rsp_rdata; end
         if (cmd_ready === 1'b1) begin
            acc[n_acc] = i; n_acc++;
            if (n_acc == 2) break;
         end
         @(negedge aclk);
      end
      @(negedge aclk);
      cmd_valid = 1'b0;
      checks++;
      if ({n_acc, acc[0]} !== {32'd2, 32'd0}) begin errors++; $display("FAIL b2b_accepts got n=%0d first=%0d exp 2 0", n_acc, acc[0]); end
      checks++;
      if (rsp_i < 0 || acc[1] != rsp_i + 1) begin
         errors++; $display("FAIL b2b_turnaround got accept=%0d rsp=%0d exp accept=rsp+1", acc[1], rsp_i);
      end
      checks++;
      if (first_data !== 32'h33333333) begin errors++; $display("FAIL b2b_data got %h exp 33333333", first_data); end
      get_rsp(w, d, r);
      checks++;
      if (d !== 32'h33333333) begin errors++; $display("FAIL b2b_second_data got %h exp 33333333", d); end
   endtask

   task automatic test_reset_mid();
      logic w; logic [31:0] d; logic [1:0] r;
      logic stray = 1'b0;
      aw_lat = 10;
      send_cmd(1'b1, 32'h00, 32'hDEADBEEF, 4'hF);
      checks++;
      if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL mid_awvalid got %b exp 1", bus.awvalid); end
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
         errors++; $display("FAIL mid_reset_state got %b exp 0000001",
            {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, cmd_ready});
      end
      aw_lat = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b0) stray = 1'b1;
         @(negedge aclk);
      end
      checks++;
      if (stray !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got stray rsp_valid"); end
      send_cmd(1'b0, 32'h00, 32'h0, 4'h0);
      get_rsp(w, d, r);
      checks++;
      if ({w, d, r} !== {1'b0, 32'h0, 2'b00}) begin
         errors++; $display("FAIL mid_fresh_read got write=%b rdata=%h resp=%b exp 0 00000000 00", w, d, r);
      end
   endtask

   initial begin
      @(negedge aclk);
      test_reset();
      test_write_read();
      test_multi();
      test_aw_w_order(3, 0, 32'hA5A5A5A5);
      test_aw_w_order(0, 3, 32'h5A5A5A5A);
      test_read_err();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
